mul_unit: RTL
=============

MUL_UNIT -- requirements
Module: mul_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clk  input  1  rising-edge clock, shared with the pipeline.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: MulStartE  input  1  MUL/MLA in Execute; this is MulOpE gated by the condition pass.
REQ-005 Port: MulAccE  input  1  1 = MLA (accumulate), 0 = MUL; taken from ALUControlE[0] when ALUControlE is 4'b0100 or 4'b0101.
REQ-006 Port: SrcAE  input  32  multiplicand (Rm).
REQ-007 Port: SrcBE  input  32  multiplier (Rs).
REQ-008 Port: AccE  input  32  accumulate operand (Rn); ignored when MulAccE=0.
REQ-009 Port: FlushE  input  1  Execute flush from the hazard unit.
REQ-010 Port: MulStallE  output  1  holds F/D/E while the multiply is in progress.
REQ-011 Port: MulDoneE  output  1  one-cycle pulse; MulResultE is valid in that cycle.
REQ-012 Port: MulResultE  output  32  low 32 bits of (SrcAE*SrcBE [+AccE]).
REQ-013 Port: MulFlagsE  output  2  {N,Z} of MulResultE; valid only while MulDoneE=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 IDLE: if MulStartE=1 and FlushE=0, the block SHALL load the registers as follows and go to BUSY.
- multiplicand reg = SrcAE.
- multiplier reg = SrcBE.
- accumulator = AccE if MulAccE=1, else 0.
- iteration counter = 0.
REQ-016 IDLE: MulStartE SHALL be sampled only in IDLE; MulStartE held high during BUSY or DONE SHALL NOT restart the block.
REQ-017 BUSY, each cycle:
- if multiplier reg[0]=1, accumulator += multiplicand reg (mod 2^32);
- multiplicand reg SHALL shift left by 1;
- multiplier reg SHALL shift right (logical) by 1;
- the counter SHALL increment.
REQ-018 BUSY SHALL go to DONE after the iteration with counter = 31 (32 BUSY cycles), unless REQ-029 applies.
REQ-019 DONE SHALL last one cycle and assert MulDoneE=1, MulResultE = accumulator, and MulFlagsE = {acc[31], acc==0}; the FSM then returns to IDLE.
REQ-020 MulStallE SHALL be (state==IDLE & MulStartE & ~FlushE) | (state==BUSY); it SHALL be combinational so the start cycle stalls.
REQ-021 MulStallE SHALL be 0 in DONE, so the instruction leaves Execute at the end of the DONE cycle with the result.
REQ-022 Start-to-done latency SHALL be 33 cycles: 1 start cycle plus 32 BUSY cycles, with MulDoneE in cycle 33 (start = cycle 0).
REQ-023 All arithmetic SHALL be unsigned modulo 2^32; this gives the correct low word for signed operands as well.
REQ-024 FlushE=1 in BUSY or DONE SHALL force IDLE at the next edge, with MulDoneE=0 in that cycle and no result delivered.
REQ-025 FlushE=1 together with MulStartE in IDLE SHALL NOT start the block.
REQ-026 Outside DONE, MulDoneE SHALL be 0, and MulResultE and MulFlagsE SHALL hold their last values.

Reset
REQ-027 reset=1 at a clock edge SHALL force IDLE and clear every internal register to 0, including mid-operation; an in-flight result is discarded.
REQ-028 Reset values of the outputs SHALL be MulStallE=0, MulDoneE=0, MulResultE=32'h0 and MulFlagsE=2'b00; reset SHALL take priority over FlushE and MulStartE.

Configuration
REQ-029 With macro MUL_EARLY_TERM_EN defined, early termination SHALL apply:
- BUSY SHALL go to DONE after the first iteration whose shifted multiplier reg is 0;
- if SrcBE=0 at start, IDLE SHALL go directly to DONE, giving a 1-cycle stall and MulDoneE in cycle 1;
- BUSY cycles = bit index of the highest set bit of SrcBE + 1.
REQ-030 Without MUL_EARLY_TERM_EN, latency SHALL be fixed per REQ-022 for every operand value; results SHALL be identical in both builds.

Verification
REQ-031 MUL, SrcAE=7, SrcBE=6, no macro -> MulStallE high for cycles 0..32, MulDoneE in cycle 33, MulResultE=42, MulFlagsE=2'b00.
REQ-032 MLA, SrcAE=32'hFFFFFFFF, SrcBE=1, AccE=1 -> MulResultE=0, MulFlagsE=2'b01 (Z); with no macro MulDoneE is in cycle 33.
REQ-033 MUL_EARLY_TERM_EN: SrcBE=6 -> 3 BUSY cycles, MulStallE high for cycles 0..3, MulDoneE in cycle 4, result 42.
REQ-034 MUL_EARLY_TERM_EN: SrcBE=0 -> MulDoneE in cycle 1 with result 0 for MUL, or AccE for MLA.
REQ-035 FlushE pulse in BUSY cycle 10 -> IDLE next cycle, MulStallE=0, and no MulDoneE pulse.
REQ-036 reset in BUSY cycle 5, then a new start with SrcAE=3, SrcBE=5 -> outputs cleared, then correct result 15 with full latency.

Source files
------------

// File: rtl/mul_unit_if.sv
// ---------------------------------------------------------------------------
// mul_unit_if -- Execute-stage multiplier handshake bundle.
//
// Groups the pipeline <-> multiplier signals so the Execute stage and the
// multiplier share one connection point.
//
// Signals:
//   MulStartE  (pipe -> mul) 1  MUL/MLA in Execute, already condition-gated
//   MulAccE    (pipe -> mul) 1  1 = MLA (accumulate), 0 = MUL
//   SrcAE      (pipe -> mul) 32 multiplicand (Rm)
//   SrcBE      (pipe -> mul) 32 multiplier (Rs)
//   AccE       (pipe -> mul) 32 accumulate operand (Rn)
//   FlushE     (pipe -> mul) 1  Execute flush from the hazard unit
//   MulStallE  (mul -> pipe) 1  hold F/D/E while the multiply runs
//   MulDoneE   (mul -> pipe) 1  one-cycle pulse, result valid
//   MulResultE (mul -> pipe) 32 low word of SrcAE*SrcBE [+AccE]
//   MulFlagsE  (mul -> pipe) 2  {N,Z} of MulResultE
//
// Modports: slave = multiplier side, master = pipeline side.
// ---------------------------------------------------------------------------
interface mul_unit_if;
  logic        MulStartE;
  logic        MulAccE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic [31:0] AccE;
  logic        FlushE;
  logic        MulStallE;
  logic        MulDoneE;
  logic [31:0] MulResultE;
  logic [1:0]  MulFlagsE;

  modport slave (
    input  MulStartE,
    input  MulAccE,
    input  SrcAE,
    input  SrcBE,
    input  AccE,
    input  FlushE,
    output MulStallE,
    output MulDoneE,
    output MulResultE,
    output MulFlagsE
  );

  modport master (
    output MulStartE,
    output MulAccE,
    output SrcAE,
    output SrcBE,
    output AccE,
    output FlushE,
    input  MulStallE,
    input  MulDoneE,
    input  MulResultE,
    input  MulFlagsE
  );
endinterface

// File: rtl/mul_unit.sv
// ---------------------------------------------------------------------------
// mul_unit -- iterative shift-and-add 32x32 multiplier (low word) for the
// Execute stage, supporting MUL and MLA.
//
// Ports:
//   clk    input   rising-edge clock shared with the pipeline
//   reset  input   synchronous active-high reset
//   bus    mul_unit_if.slave  handshake/operand/result bundle
//
// Operation: a start in IDLE latches the operands and stalls the pipeline
// combinationally in that same cycle. BUSY then retires one multiplier bit
// per cycle. DONE presents the result for exactly one cycle with the stall
// released, so the instruction leaves Execute carrying the result.
//
// Build option: define MUL_EARLY_TERM_EN to leave BUSY as soon as the
// remaining multiplier bits are all zero (and to skip BUSY entirely for a
// zero multiplier). Results are identical in both builds; only latency
// changes. Without the macro every multiply takes 32 BUSY cycles.
// ---------------------------------------------------------------------------
module mul_unit (
  input  logic             clk,
  input  logic             reset,
  mul_unit_if.slave        bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [31:0] mcand_q,  mcand_d;   // multiplicand, shifts left
  logic [31:0] mplr_q,   mplr_d;    // multiplier, shifts right
  logic [31:0] acc_q,    acc_d;     // running partial sum
  logic [4:0]  cnt_q,    cnt_d;     // iteration index within BUSY
  logic [31:0] result_q, result_d;  // last delivered result
  logic [1:0]  flags_q,  flags_d;   // last delivered {N,Z}

  logic        start_ok;
  logic        last_iter;
  logic        deliver;
  logic [31:0] acc_step;
  logic [1:0]  acc_flags;

  // A start is honoured only from IDLE and never together with a flush.
  assign start_ok  = (state_q == ST_IDLE) && bus.MulStartE && !bus.FlushE;

  // The result is handed over only in an unflushed DONE cycle.
  assign deliver   = (state_q == ST_DONE) && !bus.FlushE;

  // One shift-and-add step: add the multiplicand when the current
  // multiplier LSB is set. Wraps modulo 2^32, which is also the correct
  // low word for two's-complement operands.
  assign acc_step  = acc_q + (mplr_q[0] ? mcand_q : 32'h0);

  assign acc_flags = {acc_q[31], (acc_q == 32'h0)};

`ifdef MUL_EARLY_TERM_EN
  // Finish after the iteration that leaves no set bits in the shifted
  // multiplier. The counter bound is kept as a backstop; it coincides with
  // the multiplier emptying out anyway.
  assign last_iter = (mplr_q[31:1] == 31'h0) || (cnt_q == 5'd31);
`else
  assign last_iter = (cnt_q == 5'd31);
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          mcand_d = bus.SrcAE;
          mplr_d  = bus.SrcBE;
          acc_d   = bus.MulAccE ? bus.AccE : 32'h0;
          cnt_d   = 5'd0;
`ifdef MUL_EARLY_TERM_EN
          // A zero multiplier contributes nothing: the accumulator already
          // holds the final answer.
          state_d = (bus.SrcBE == 32'h0) ? ST_DONE : ST_BUSY;
`else
          state_d = ST_BUSY;
`endif
        end
      end

      ST_BUSY: begin
        acc_d   = acc_step;
        mcand_d = {mcand_q[30:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[31:1]};
        cnt_d   = cnt_q + 5'd1;
        if (bus.FlushE) begin
          state_d = ST_IDLE;
        end else if (last_iter) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (deliver) begin
          result_d = acc_q;
          flags_d  = acc_flags;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers; reset wins over flush and start.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= 32'h0;
      mplr_q   <= 32'h0;
      acc_q    <= 32'h0;
      cnt_q    <= 5'd0;
      result_q <= 32'h0;
      flags_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // The stall must cover the start cycle itself, hence the combinational
  // IDLE term. DONE is deliberately excluded so the instruction retires.
  assign bus.MulStallE  = start_ok || (state_q == ST_BUSY);
  assign bus.MulDoneE   = deliver;

  // During DONE the live accumulator is shown; otherwise the last delivered
  // value is held.
  assign bus.MulResultE = deliver ? acc_q     : result_q;
  assign bus.MulFlagsE  = deliver ? acc_flags : flags_q;

endmodule
